datapath: RTL and testbench

SAP-class 8-bit datapath that executes the 16-bit control words issued by the microcode sequencer. It contains the bus, A/B registers, ALU, flags, program counter, memory address register, 16×8 RAM, instruction register and output register. It returns the current opcode to the sequencer and exposes the output value and halt status to the top level. It also provides a RAM preload port that is usable while the block is held in reset.

---
 rtl/datapath.sv | 165 ++++++++++++++++
 tb/tb_datapath.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// SAP-class 8-bit datapath: bus, A/B, ALU, flags, PC, MAR, 16x8 RAM, IR and output register.
// Define DATAPATH_BUS_CHECK_EN to build the sticky multi-driver bus_conflict detector.
module datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ctrl_data,
    output logic [3:0]  instruction,
    output logic [7:0]  out_value,
    output logic        out_valid,
    output logic        halted,
    output logic        flag_c,
    output logic        flag_z,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [7:0]  prog_data,
    output logic        bus_conflict
);

    logic hlt, mi, ri, ro, io, ii, ai, ao;
    logic eo, su, bi, oi, ce, co, jmp, fi;

    assign hlt = ctrl_data[15];
    assign mi  = ctrl_data[14];
    assign ri  = ctrl_data[13];
    assign ro  = ctrl_data[12];
    assign io  = ctrl_data[11];
    assign ii  = ctrl_data[10];
    assign ai  = ctrl_data[9];
    assign ao  = ctrl_data[8];
    assign eo  = ctrl_data[7];
    assign su  = ctrl_data[6];
    assign bi  = ctrl_data[5];
    assign oi  = ctrl_data[4];
    assign ce  = ctrl_data[3];
    assign co  = ctrl_data[2];
    assign jmp = ctrl_data[1];
    assign fi  = ctrl_data[0];

    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] ir_q, ir_d;
    logic [3:0] mar_q, mar_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] out_q, out_d;
    logic       ov_q, ov_d;
    logic       fc_q, fc_d;
    logic       fz_q, fz_d;
    logic       halted_q, halted_d;
    logic [7:0] ram_q [16];
    logic       ram_we;

    logic [7:0] bus;
    logic [8:0] alu_sum;
    logic [7:0] alu_r;
    logic       alu_c;

    always_comb begin
        bus = '0;
        if (ro)      bus = ram_q[mar_q];
        else if (io) bus = {4'h0, ir_q[3:0]};
        else if (ao) bus = a_q;
        else if (eo) bus = alu_r;
        else if (co) bus = {4'h0, pc_q};
    end

    // Subtract as A + ~B + 1 so carry-out reads as "no borrow".
    assign alu_sum = {1'b0, a_q} + {1'b0, (su ? ~b_q : b_q)} + {8'd0, su};
    assign alu_r   = alu_sum[7:0];
    assign alu_c   = alu_sum[8];

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        ir_d     = ir_q;
        mar_d    = mar_q;
        pc_d     = pc_q;
        out_d    = out_q;
        ov_d     = 1'b0;
        fc_d     = fc_q;
        fz_d     = fz_q;
        halted_d = halted_q;
        ram_we   = 1'b0;
        if (!halted_q) begin
            if (mi) mar_d = bus[3:0];
            if (ri) ram_we = 1'b1;
            if (ii) ir_d = bus;
            if (ai) a_d = bus;
            if (bi) b_d = bus;
            if (oi) begin
                out_d = bus;
                ov_d  = 1'b1;
            end
            if (fi) begin
                fc_d = alu_c;
                fz_d = (alu_r == 8'd0);
            end
            if (jmp)     pc_d = bus[3:0];
            else if (ce) pc_d = pc_q + 4'd1;
            if (hlt) halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            ir_q     <= '0;
            mar_q    <= '0;
            pc_q     <= '0;
            out_q    <= '0;
            ov_q     <= 1'b0;
            fc_q     <= 1'b0;
            fz_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            ir_q     <= ir_d;
            mar_q    <= mar_d;
            pc_q     <= pc_d;
            out_q    <= out_d;
            ov_q     <= ov_d;
            fc_q     <= fc_d;
            fz_q     <= fz_d;
            halted_q <= halted_d;
        end
    end

    // RAM is never cleared; the preload port only writes while reset is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (prog_we) ram_q[prog_addr] <= prog_data;
        end else if (ram_we) begin
            ram_q[mar_q] <= bus;
        end
    end

`ifdef DATAPATH_BUS_CHECK_EN
    logic       bc_q, bc_d;
    logic [2:0] n_drv;

    always_comb begin
        n_drv = {2'b0, ro} + {2'b0, io} + {2'b0, ao} + {2'b0, eo} + {2'b0, co};
        bc_d  = bc_q;
        if (!halted_q && (n_drv >= 3'd2)) bc_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) bc_q <= 1'b0;
        else     bc_q <= bc_d;
    end

    assign bus_conflict = bc_q;
`else
    assign bus_conflict = 1'b0;
`endif

    assign instruction = ir_q[7:4];
    assign out_value   = out_q;
    assign out_valid   = ov_q;
    assign halted      = halted_q;
    assign flag_c      = fc_q;
    assign flag_z      = fz_q;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: table-driven control words with an output scoreboard,
// plus hand sequences for reset/preload, halt and bus-conflict behaviour.
module tb_datapath;

    localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, JP = 16'h0002, FI = 16'h0001;
`ifdef DATAPATH_BUS_CHECK_EN
    localparam logic BC_EXP = 1'b1;
`else
    localparam logic BC_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ctrl_data = '0;
    logic [3:0]  instruction;
    logic [7:0]  out_value;
    logic        out_valid, halted, flag_c, flag_z, bus_conflict;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [7:0]  prog_data = '0;

    datapath dut (
        .clk(clk), .rst(rst), .ctrl_data(ctrl_data), .instruction(instruction),
        .out_value(out_value), .out_valid(out_valid), .halted(halted),
        .flag_c(flag_c), .flag_z(flag_z), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .bus_conflict(bus_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ctrl;
        logic [7:0]  eo;
        logic        cf;
        logic        ec;
        logic        ez;
        logic        ci;
        logic [3:0]  ei;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         nchk = 0;
    int         npass = 0;
    logic       m_halt = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic void add(input logic [15:0] c, input logic [7:0] eo,
                                input logic cf, input logic ec, input logic ez,
                                input logic ci, input logic [3:0] ei);
        vec_t v;
        v.ctrl = c; v.eo = eo; v.cf = cf; v.ec = ec; v.ez = ez; v.ci = ci; v.ei = ei;
        vecs.push_back(v);
    endfunction

    function automatic void op(input logic [15:0] c);
        add(c, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endfunction

    function automatic void out(input logic [15:0] c, input logic [7:0] e);
        add(c, e, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endfunction

    // One control word per cycle; output expectations queued at drive time.
    task automatic step(input logic [15:0] c, input logic [7:0] eo);
        logic exp_ov;
        logic [7:0] e;
        @(negedge clk);
        ctrl_data = c;
        exp_ov = c[4] && !m_halt;
        if (exp_ov) sb.push_back(eo);
        if (c[15]) m_halt = 1'b1;
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_value", {24'd0, out_value}, {24'd0, e});
            end
        end
    endtask

    task automatic reset_on;
        @(negedge clk);
        rst = 1'b1;
        prog_we = 1'b0;
        ctrl_data = HLT | OI | RO | AO | AI | FI | CE;
    endtask

    task automatic pre(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        prog_we = 1'b1;
        prog_addr = a;
        prog_data = d;
    endtask

    task automatic reset_off;
        @(negedge clk);
        rst = 1'b0;
        ctrl_data = '0;
        // Preload port stays asserted afterwards; it must be ignored out of reset.
        prog_we = 1'b1;
        prog_addr = 4'h0;
        prog_data = 8'h55;
        m_halt = 1'b0;
        sb.delete();
        chk("rst_instruction", {28'd0, instruction}, 32'd0);
        chk("rst_out_value", {24'd0, out_value}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_flags", {30'd0, flag_c, flag_z}, 32'd0);
        chk("rst_bus_conflict", {31'd0, bus_conflict}, 32'd0);
    endtask

    initial begin
        // LDA/ADD
        op(CO | MI);
        op(RO | AI);
        out(AO | OI, 8'h1E);
        add(RO | II | CE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1);
        op(IO | MI);
        op(RO | AI);
        op(CO | MI);
        add(RO | II | CE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
        op(IO | MI);
        op(RO | BI);
        add(EO | AI | FI, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        out(AO | OI, 8'h2A);
        // SUB boundaries
        op(CO | MI);
        op(RO | AI);
        op(RO | BI);
        add(EO | AI | SU | FI, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        out(AO | OI, 8'h00);
        op(CE);
        op(CO | MI);
        op(RO | AI);
        add(EO | AI | SU | FI, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        out(AO | OI, 8'hFE);
        add(FI | SU, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        op(AI);
        add(FI, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        out(AO | OI, 8'h00);
        // PC, jump priority, MAR from PC, same-word writes
        op(CE);
        op(CO | MI);
        add(RO | II, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4);
        op(CE | JP | IO);
        out(CO | OI, 8'h09);
        op(CO | MI);
        out(RO | OI, 8'h99);
        op(AO | RI);
        out(RO | OI, 8'h00);
        for (int i = 0; i < 6; i++) op(CE);
        out(CO | OI, 8'h0F);
        op(CE);
        out(CO | OI, 8'h00);
        op(CE);
        op(CO | MI | RI);
        out(RO | OI, 8'h2F);
        op(IO | MI);
        out(RO | OI, 8'h01);
        for (int i = 0; i < 4; i++) op(CE);
        op(CO | MI);
        op(RO | AI);
        out(AO | OI, 8'h2A);

        reset_on;
        pre(4'd0, 8'h1E);
        pre(4'd1, 8'h2F);
        pre(4'd2, 8'h05);
        pre(4'd3, 8'h03);
        pre(4'd4, 8'h49);
        pre(4'd5, 8'h2A);
        pre(4'd9, 8'h99);
        pre(4'd14, 8'h1C);
        pre(4'd15, 8'h0E);
        reset_off;

        foreach (vecs[i]) begin
            step(vecs[i].ctrl, vecs[i].eo);
            if (vecs[i].cf) begin
                chk($sformatf("flag_c[%0d]", i), {31'd0, flag_c}, {31'd0, vecs[i].ec});
                chk($sformatf("flag_z[%0d]", i), {31'd0, flag_z}, {31'd0, vecs[i].ez});
            end
            if (vecs[i].ci)
                chk($sformatf("instruction[%0d]", i), {28'd0, instruction}, {28'd0, vecs[i].ei});
        end
        chk("no_conflict_single_drivers", {31'd0, bus_conflict}, 32'd0);

        // Halt freezes everything until reset
        step(HLT, 8'h00);
        chk("halted_set", {31'd0, halted}, 32'd1);
        step(AI | CE | RO | OI | FI | SU | MI, 8'h00);
        step(RO | AO | AI | JP, 8'h00);
        chk("halt_a", {24'd0, dut.a_q}, 32'h2A);
        chk("halt_pc", {28'd0, dut.pc_q}, 32'h5);
        chk("halt_out_value", {24'd0, out_value}, 32'h2A);
        chk("halt_flags", {30'd0, flag_c, flag_z}, 32'd0);
        chk("halt_sticky", {31'd0, halted}, 32'd1);
        chk("halt_no_conflict", {31'd0, bus_conflict}, 32'd0);
        reset_on;
        reset_off;

        // Bus priority and conflict detection
        step(CO | MI, 8'h00);
        step(RO | AO | AI, 8'h00);
        chk("bc_set", {31'd0, bus_conflict}, {31'd0, BC_EXP});
        step(AO | OI, 8'h1E);
        chk("bc_sticky", {31'd0, bus_conflict}, {31'd0, BC_EXP});
        reset_on;
        reset_off;
        step(16'h0000, 8'h00);
        chk("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
